// File: rtl/alu_muldiv_unit_pkg.sv
// Shared op codes, FSM states and mul/div decode helpers for alu_muldiv_unit.

`define IS_MULDIV(op) (((op) >= alu_muldiv_unit_pkg::ALU_OP_MUL) && ((op) <= alu_muldiv_unit_pkg::ALU_OP_REMU))

package alu_muldiv_unit_pkg;

  localparam int ALU_OP_W = 5;

  // Base integer ALU ops (existing encodings)
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD    = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB    = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND    = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR     = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR    = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT    = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU   = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL    = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL    = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA    = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDI   = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ANDI   = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ORI    = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XORI   = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTI   = 5'd14;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTIU  = 5'd15;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLLI   = 5'd16;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRLI   = 5'd17;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRAI   = 5'd18;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LUI    = 5'd19;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AUIPC  = 5'd20;

  // RV-M ops appended after the base set
  localparam logic [ALU_OP_W-1:0] ALU_OP_MUL    = 5'd21;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MULH   = 5'd22;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MULHSU = 5'd23;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MULHU  = 5'd24;
  localparam logic [ALU_OP_W-1:0] ALU_OP_DIV    = 5'd25;
  localparam logic [ALU_OP_W-1:0] ALU_OP_DIVU   = 5'd26;
  localparam logic [ALU_OP_W-1:0] ALU_OP_REM    = 5'd27;
  localparam logic [ALU_OP_W-1:0] ALU_OP_REMU   = 5'd28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Control bits the iterative datapath needs for one mul/div op
  typedef struct packed {
    logic is_div;
    logic signed_a;
    logic signed_b;
    logic sel_high;   // high product half for MULH*, remainder for REM*
  } md_ctrl_t;

  function automatic md_ctrl_t decode_muldiv(input logic [ALU_OP_W-1:0] op);
    md_ctrl_t c;
    c.is_div   = (op == ALU_OP_DIV) || (op == ALU_OP_DIVU) ||
                 (op == ALU_OP_REM) || (op == ALU_OP_REMU);
    c.signed_a = (op == ALU_OP_MUL) || (op == ALU_OP_MULH) || (op == ALU_OP_MULHSU) ||
                 (op == ALU_OP_DIV) || (op == ALU_OP_REM);
    c.signed_b = (op == ALU_OP_MUL) || (op == ALU_OP_MULH) ||
                 (op == ALU_OP_DIV) || (op == ALU_OP_REM);
    c.sel_high = (op == ALU_OP_MULH) || (op == ALU_OP_MULHSU) || (op == ALU_OP_MULHU) ||
                 (op == ALU_OP_REM) || (op == ALU_OP_REMU);
    return c;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide, one step per clock, XLEN steps per op.
// Operands are converted to magnitudes on start and the sign is applied to the final result.

module alu_muldiv_iter
  import alu_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            kill,
  input  logic            start,
  input  md_ctrl_t        ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic              busy_q;
  logic [CNT_W-1:0]  count_q;
  logic              is_div_q;
  logic              sel_high_q;
  logic              neg_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   divisor_q;

  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] prod_nxt;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_nxt;
  logic [2*XLEN-1:0] mul_signed;
  logic [XLEN-1:0]   div_raw;

  assign neg_a = ctrl.signed_a && op_a[XLEN-1];
  assign neg_b = ctrl.signed_b && op_b[XLEN-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;

  // One shift-add and one restoring-subtract step, plus the sign-corrected final result
  always_comb begin
    prod_nxt  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, divisor_q};
    if (!rem_diff[XLEN]) begin
      rem_nxt = rem_diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_shift[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
    mul_signed = neg_q ? -prod_nxt : prod_nxt;
    div_raw    = sel_high_q ? rem_nxt : quo_nxt;
    if (is_div_q) begin
      result = neg_q ? -div_raw : div_raw;
    end else begin
      result = sel_high_q ? mul_signed[2*XLEN-1:XLEN] : mul_signed[XLEN-1:0];
    end
  end

  assign done = busy_q && (count_q == CNT_LAST);

  // Load operands on start, then advance one step per cycle until the last count
  always_ff @(posedge clk) begin
    if (kill) begin
      busy_q  <= 1'b0;
      count_q <= '0;
    end else if (start) begin
      busy_q     <= 1'b1;
      count_q    <= '0;
      is_div_q   <= ctrl.is_div;
      sel_high_q <= ctrl.sel_high;
      neg_q      <= (ctrl.is_div && ctrl.sel_high) ? neg_a : (neg_a ^ neg_b);
      prod_q     <= '0;
      mcand_q    <= {{XLEN{1'b0}}, mag_a};
      mplier_q   <= mag_b;
      rem_q      <= '0;
      quo_q      <= mag_a;
      divisor_q  <= mag_b;
    end else if (busy_q) begin
      prod_q   <= prod_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= rem_nxt;
      quo_q    <= quo_nxt;
      count_q  <= count_q + CNT_W'(1);
      if (count_q == CNT_LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Integer ALU with iterative RV-M multiply/divide, valid/ready on both sides and flush support.
// Base ops and divide special cases complete in one cycle; other mul/div ops go through alu_muldiv_iter.

module alu_muldiv_unit
  import alu_muldiv_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int OP_W      = 5,
  parameter int ROB_TAG_W = 6,
  parameter int PREG_W    = 6,
  parameter int PC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [ROB_TAG_W-1:0] in_rob_tag,
  input  logic [PREG_W-1:0]    in_prd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [ROB_TAG_W-1:0] out_rob_tag,
  output logic [PREG_W-1:0]    out_prd
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e                state_q;
  state_e                state_nxt;
  logic [ALU_OP_W-1:0]   op;
  logic                  accept;
  logic                  is_imm_form;
  logic                  div_zero;
  logic                  div_ovf;
  logic                  fast_path;
  logic                  is_md;
  logic [XLEN-1:0]       op2;
  logic [SHW-1:0]        shamt;
  logic [XLEN-1:0]       pc_ext;
  logic [XLEN-1:0]       alu_res;
  logic                  iter_done;
  logic [XLEN-1:0]       iter_res;

  assign op          = ALU_OP_W'(in_op);
  assign in_ready    = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept      = in_valid && in_ready;
  assign is_imm_form = (op >= ALU_OP_ADDI) && (op <= ALU_OP_SRAI);
  assign op2         = is_imm_form ? in_imm : in_rs2;
  assign shamt       = op2[SHW-1:0];
  assign pc_ext      = XLEN'(in_pc);
  assign div_zero    = (in_rs2 == '0);
  assign div_ovf     = (in_rs1 == MIN_INT) && (in_rs2 == '1);
  assign fast_path   = (div_zero && ((op == ALU_OP_DIV) || (op == ALU_OP_DIVU) ||
                                     (op == ALU_OP_REM) || (op == ALU_OP_REMU))) ||
                       (div_ovf && ((op == ALU_OP_DIV) || (op == ALU_OP_REM)));
  assign is_md       = `IS_MULDIV(op) && !fast_path;
  assign out_valid   = (state_q == ST_DONE);

  // Single-cycle result for base ops and the divide-by-zero / overflow shortcuts
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_OP_ADD, ALU_OP_ADDI:   alu_res = in_rs1 + op2;
      ALU_OP_SUB:                alu_res = in_rs1 - in_rs2;
      ALU_OP_AND, ALU_OP_ANDI:   alu_res = in_rs1 & op2;
      ALU_OP_OR,  ALU_OP_ORI:    alu_res = in_rs1 | op2;
      ALU_OP_XOR, ALU_OP_XORI:   alu_res = in_rs1 ^ op2;
      ALU_OP_SLT, ALU_OP_SLTI:   alu_res = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(op2))};
      ALU_OP_SLTU, ALU_OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, (in_rs1 < op2)};
      ALU_OP_SLL, ALU_OP_SLLI:   alu_res = in_rs1 << shamt;
      ALU_OP_SRL, ALU_OP_SRLI:   alu_res = in_rs1 >> shamt;
      ALU_OP_SRA, ALU_OP_SRAI:   alu_res = $signed(in_rs1) >>> shamt;
      ALU_OP_LUI:                alu_res = in_imm;
      ALU_OP_AUIPC:              alu_res = pc_ext + in_imm;
      ALU_OP_DIVU:               alu_res = div_zero ? '1 : '0;
      ALU_OP_DIV:                alu_res = div_zero ? '1 : (div_ovf ? MIN_INT : '0);
      ALU_OP_REM, ALU_OP_REMU:   alu_res = div_zero ? in_rs1 : '0;
      default:                   alu_res = '0;
    endcase
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_nxt = is_md ? ST_CALC : ST_DONE;
      end
      ST_CALC: begin
        if (iter_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (accept)         state_nxt = is_md ? ST_CALC : ST_DONE;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Output register: tags captured on accept, result on accept (fast ops) or at the last iterative step
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result  <= '0;
      out_rob_tag <= '0;
      out_prd     <= '0;
    end else if (accept) begin
      out_rob_tag <= in_rob_tag;
      out_prd     <= in_prd;
      if (!is_md) out_result <= alu_res;
    end else if ((state_q == ST_CALC) && iter_done && !flush) begin
      out_result <= iter_res;
    end
  end

  alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk    (clk),
    .kill   (flush | rst),
    .start  (accept && is_md),
    .ctrl   (decode_muldiv(op)),
    .op_a   (in_rs1),
    .op_b   (in_rs2),
    .done   (iter_done),
    .result (iter_res)
  );

endmodule
